fpga_ccff_loader: RTL
=====================

Name: fpga_ccff_loader

Overview:
Sequences configuration of fpga_top through its NUM_CHAINS parallel configuration-chain flip-flop (ccff) shift chains. Accepts a bitstream over a valid/ready stream, one bit per chain per word. Drives pReset, config_enable, prog_clk, ccff_head and IO_ISOL_N in the required order. Sits between the SoC bitstream source (DMA/SPI bridge) and fpga_top, in place of the constant ties used for pre-configured simulation.

Parameters:
NUM_CHAINS, 12, number of parallel ccff chains (width of ccff_head/ccff_tail)
CHAIN_LEN, 2048, bits per chain, i.e. words per full load; must be >= 1
PRESET_CYCLES, 4, cycles pReset is held high before shifting; must be >= 1
CNT_W, $clog2(CHAIN_LEN+1), width of the word counter

Ports:
clk  in  1  system clock; all logic is on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a full configuration load
abort  in  1  cancels any load and returns to IDLE; has priority over start
in_valid  in  1  bitstream word valid
in_data  in  NUM_CHAINS  bitstream word; bit i feeds chain i
in_ready  out  1  loader accepts in_data this cycle
ccff_tail  in  NUM_CHAINS  chain outputs from fpga_top
ccff_head  out  NUM_CHAINS  chain inputs to fpga_top
prog_clk  out  1  configuration shift clock, generated as a registered level
config_enable  out  1  configuration-mode enable to fabric
pReset  out  1  active-high configuration-memory reset
IO_ISOL_N  out  1  active-low I/O isolation; low isolates the pads
busy  out  1  load in progress
done  out  1  fabric configured; I/O released
tail_sig  out  NUM_CHAINS  XOR signature of ccff_tail over the last load

Behaviour:
- All outputs are registered (Moore). Reset values: state=IDLE, ccff_head=0, prog_clk=0, config_enable=0, pReset=0, IO_ISOL_N=0, in_ready=0, busy=0, done=0, tail_sig=0, word_cnt=0.
- States:
  - IDLE
  - PRESET: pReset=1 for PRESET_CYCLES cycles.
  - ENABLE: config_enable=1 for 1 setup cycle.
  - SHIFT_LO: prog_clk=0, in_ready=1.
  - SHIFT_HI: prog_clk=1, in_ready=0.
  - DISABLE: config_enable=0 for 1 cycle.
  - DONE
- IDLE or DONE with start=1: go to PRESET. Clear tail_sig and word_cnt, drive IO_ISOL_N=0 and done=0. Reconfiguration from DONE is legal.
- config_enable stays 1 from ENABLE through the last SHIFT_HI.
- SHIFT_LO: on in_valid&&in_ready, register ccff_head<=in_data and go to SHIFT_HI. Otherwise hold, with prog_clk=0 and ccff_head stable. Stalls of any length are legal.
- SHIFT_HI (exactly 1 cycle):
  - Update tail_sig <= tail_sig ^ ccff_tail.
  - Increment word_cnt.
  - If word_cnt == CHAIN_LEN-1 (pre-increment), go to DISABLE; otherwise go to SHIFT_LO.
  - ccff_head must not change while prog_clk=1.
- DISABLE: go to DONE.
- DONE: done=1, IO_ISOL_N=1, pReset=0, config_enable=0. Hold until start.
- busy=1 in every state except IDLE and DONE.
- Latency: with in_valid held high, done rises after edge number PRESET_CYCLES+2*CHAIN_LEN+2, counting the edge that samples start as edge 0.
- Ignored requests: start while busy is ignored. in_valid outside SHIFT_LO is never accepted (in_ready=0).
- abort=1 in any state forces IDLE on the next edge with prog_clk=0, config_enable=0, pReset=0, IO_ISOL_N=0, done=0, word_cnt=0. ccff_head and tail_sig are held. abort together with start: abort wins.
- reset mid-load has the same effect as abort and also clears ccff_head and tail_sig.
- word_cnt never wraps; it saturates conceptually at CHAIN_LEN because the FSM leaves SHIFT first.

Decomposition:
- Shared package fpga_ccff_pkg holds:
  - state enum ccff_state_t {IDLE, PRESET, ENABLE, SHIFT_LO, SHIFT_HI, DISABLE, DONE}
  - NUM_CHAINS_DEFAULT=12
- One natural sub-module, fpga_ccff_presetcnt: a down-counter that loads PRESET_CYCLES and raises a terminal flag. Everything else stays in the top FSM.

Test Plan:
- Reset: hold reset for 3 cycles -> every output at its reset value, IO_ISOL_N=0, busy=0.
- Nominal load, CHAIN_LEN=3, PRESET_CYCLES=4, in_valid always high with words 0x001, 0x802, 0xFFF:
  - pReset high for exactly 4 cycles.
  - 3 prog_clk pulses with ccff_head=0x001, 0x802, 0xFFF during them.
  - done=1 and IO_ISOL_N=1 after edge 12.
- Tail signature: ccff_tail driven 0x00F, 0x0F0, 0xF00 on the three SHIFT_HI cycles -> tail_sig=0xFFF at done.
- Backpressure: in_valid deasserted for 5 cycles before the second word -> prog_clk stays 0 and ccff_head holds 0x001 throughout; done is delayed by exactly 5 cycles.
- Abort mid-shift after word 2 -> IDLE next edge with config_enable=0, prog_clk=0, IO_ISOL_N=0, done=0. A following start then performs a full PRESET again.
- Start while busy, start in DONE, and abort+start same cycle:
  - start pulse during SHIFT is ignored.
  - start in DONE drops IO_ISOL_N and done on the next edge and reloads.
  - abort with start in the same cycle -> IDLE.

Source files
------------

// File: rtl/fpga_ccff_pkg.sv
// Shared types and defaults for the ccff configuration loader.
package fpga_ccff_pkg;

  localparam int NUM_CHAINS_DEFAULT = 12;

  typedef enum logic [2:0] {
    IDLE,
    PRESET,
    ENABLE,
    SHIFT_LO,
    SHIFT_HI,
    DISABLE,
    DONE
  } ccff_state_t;

endpackage

// File: rtl/fpga_ccff_presetcnt.sv
// Down-counter timing how long configuration memory is held in reset.
// 'term' is high once the loaded count has run down to zero.
module fpga_ccff_presetcnt
  import fpga_ccff_pkg::*;
#(
  parameter int PRESET_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic term
);

  localparam int PW = (PRESET_CYCLES > 1) ? $clog2(PRESET_CYCLES) : 1;

  logic [PW-1:0] cnt;

  // Loading PRESET_CYCLES-1 makes term appear on the last cycle of the window
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= PW'(PRESET_CYCLES - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign term = (cnt == '0);

endmodule

// File: rtl/fpga_ccff_loader.sv
// Drives fpga_top's ccff chains from a valid/ready bitstream: preset,
// enable, one prog_clk pulse per word, disable, then release the I/O.
module fpga_ccff_loader
  import fpga_ccff_pkg::*;
#(
  parameter int NUM_CHAINS    = NUM_CHAINS_DEFAULT,
  parameter int CHAIN_LEN     = 2048,
  parameter int PRESET_CYCLES = 4,
  parameter int CNT_W         = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [NUM_CHAINS-1:0] in_data,
  output logic                  in_ready,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic [NUM_CHAINS-1:0] ccff_head,
  output logic                  prog_clk,
  output logic                  config_enable,
  output logic                  pReset,
  output logic                  IO_ISOL_N,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_CHAINS-1:0] tail_sig
);

  ccff_state_t      state, next_state;
  logic [CNT_W-1:0] word_cnt;
  logic             start_go;
  logic             accept;
  logic             last_word;
  logic             preset_term;

  fpga_ccff_presetcnt #(
    .PRESET_CYCLES(PRESET_CYCLES)
  ) u_presetcnt (
    .clk  (clk),
    .reset(reset),
    .load (start_go),
    .en   (state == PRESET),
    .term (preset_term)
  );

  assign accept = in_valid && in_ready;

  always_comb begin
    start_go   = start && !abort && ((state == IDLE) || (state == DONE));
    last_word  = (word_cnt == CNT_W'(CHAIN_LEN - 1));
    next_state = state;
    unique case (state)
      IDLE, DONE: if (start_go) next_state = PRESET;
      PRESET:     if (preset_term) next_state = ENABLE;
      ENABLE:     next_state = SHIFT_LO;
      SHIFT_LO:   if (accept) next_state = SHIFT_HI;
      SHIFT_HI:   next_state = last_word ? DISABLE : SHIFT_LO;
      DISABLE:    next_state = DONE;
      default:    next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  // Outputs are decoded from next_state so every pin is a flop (Moore)
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ccff_head     <= '0;
      prog_clk      <= 1'b0;
      config_enable <= 1'b0;
      pReset        <= 1'b0;
      IO_ISOL_N     <= 1'b0;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      tail_sig      <= '0;
      word_cnt      <= '0;
    end else begin
      state         <= next_state;
      prog_clk      <= (next_state == SHIFT_HI);
      in_ready      <= (next_state == SHIFT_LO);
      pReset        <= (next_state == PRESET);
      config_enable <= (next_state == ENABLE) || (next_state == SHIFT_LO) ||
                       (next_state == SHIFT_HI);
      busy          <= (next_state != IDLE) && (next_state != DONE);
      done          <= (next_state == DONE);
      IO_ISOL_N     <= (next_state == DONE);

      // Head only moves on the low phase, so it is stable under prog_clk=1
      if ((state == SHIFT_LO) && accept && !abort) begin
        ccff_head <= in_data;
      end

      if (start_go) begin
        tail_sig <= '0;
      end else if ((state == SHIFT_HI) && !abort) begin
        tail_sig <= tail_sig ^ ccff_tail;
      end

      if (start_go || abort) begin
        word_cnt <= '0;
      end else if (state == SHIFT_HI) begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

endmodule
